// File: rtl/rf_wb_arbiter.sv
// Arbitrates register-file writeback between the pipeline and an auxiliary multicycle unit.
// The pipeline normally wins; a starved aux request gets one forced priority cycle.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_wsel,
  input  logic [31:0] pipe_wdat,
  output logic        pipe_stall,
  input  logic        aux_valid,
  input  logic [4:0]  aux_wsel,
  input  logic [31:0] aux_wdat,
  output logic        aux_ready,
  output logic        rf_WEN,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic        prio_active
);

  localparam logic [0:0] StNormal   = 1'b0;
  localparam logic [0:0] StPriority = 1'b1;
  localparam logic [3:0] LimitM1    = 4'(STARVE_LIMIT - 1);

  logic [0:0]  r_state;
  logic [0:0]  w_state_d;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_cnt_d;

  logic        w_pipe_req;
  logic        w_aux_req;
  logic        w_force;
  logic        w_aux_ready;
  logic        w_stall;
  logic        w_blocked;
  logic        w_wen;
  logic [4:0]  w_wsel;
  logic [31:0] w_wdat;

  always_comb begin
    w_pipe_req  = pipe_wen && (pipe_wsel != 5'd0);
    w_aux_req   = aux_valid && (aux_wsel != 5'd0);
    w_force     = (r_state == StPriority) && w_aux_req;
    w_aux_ready = 1'b0;
    w_stall     = 1'b0;
    w_blocked   = 1'b0;
    w_wen       = 1'b0;
    w_wsel      = 5'd0;
    w_wdat      = 32'd0;

    // Writes to r0 are acknowledged and dropped.
    if (aux_valid && (aux_wsel == 5'd0)) begin
      w_aux_ready = 1'b1;
    end

    if (w_force) begin
      w_aux_ready = 1'b1;
      w_stall     = 1'b1;
      w_wen       = 1'b1;
      w_wsel      = aux_wsel;
      w_wdat      = aux_wdat;
    end else if (w_pipe_req) begin
      w_wen  = 1'b1;
      w_wsel = pipe_wsel;
      w_wdat = pipe_wdat;
      // Same destination: the pipe result is younger, so the aux write is simply retired.
      if (w_aux_req) begin
        if (aux_wsel == pipe_wsel) begin
          w_aux_ready = 1'b1;
        end else begin
          w_blocked = 1'b1;
        end
      end
    end else if (w_aux_req) begin
      w_aux_ready = 1'b1;
      w_wen       = 1'b1;
      w_wsel      = aux_wsel;
      w_wdat      = aux_wdat;
    end
  end

  always_comb begin
    w_state_d    = StNormal;
    w_wait_cnt_d = w_blocked ? (r_wait_cnt + 4'd1) : 4'd0;
    if ((r_state == StNormal) && w_blocked && (r_wait_cnt == LimitM1)) begin
      w_state_d = StPriority;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= StNormal;
      r_wait_cnt <= 4'd0;
      rf_WEN     <= 1'b0;
      rf_wsel    <= 5'd0;
      rf_wdat    <= 32'd0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_cnt_d;
      rf_WEN     <= w_wen;
      rf_wsel    <= w_wsel;
      rf_wdat    <= w_wdat;
    end
  end

  assign aux_ready   = w_aux_ready & nRST;
  assign pipe_stall  = w_stall & nRST;
  assign prio_active = (r_state == StPriority);

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive blocked aux cycles before forced aux priority (legal 1..15).
REQ-002 Port: CLK  in  1  system clock, all state updates on posedge.
REQ-003 Port: nRST  in  1  reset, asynchronous, active-low.
REQ-004 Port: pipe_wen  in  1  pipeline writeback request.
REQ-005 Port: pipe_wsel  in  5  pipeline destination register.
REQ-006 Port: pipe_wdat  in  32  pipeline writeback data.
REQ-007 Port: pipe_stall  out  1  freeze pipeline; current pipe writeback not performed, re-presented next cycle.
REQ-008 Port: aux_valid  in  1  auxiliary (multicycle unit) write request.
REQ-009 Port: aux_wsel  in  5  auxiliary destination register.
REQ-010 Port: aux_wdat  in  32  auxiliary write data.
REQ-011 Port: aux_ready  out  1  aux request consumed at this posedge.
REQ-012 Port: rf_WEN  out  1  register-file write enable.
REQ-013 Port: rf_wsel  out  5  register-file write select.
REQ-014 Port: rf_wdat  out  32  register-file write data.
REQ-015 Port: prio_active  out  1  high while in state PRIORITY.

Function
REQ-016 The block SHALL implement a two-state FSM: NORMAL, PRIORITY; reset state NORMAL.
REQ-017 A pipe request SHALL exist only when pipe_wen=1 and pipe_wsel!=0.
REQ-018 In NORMAL, a pipe request SHALL always be granted; pipe_stall=0.
REQ-019 In NORMAL with no pipe request, aux_ready SHALL equal aux_valid (aux granted).
REQ-020 In NORMAL, aux_valid with pipe request and aux_wsel==pipe_wsel SHALL give aux_ready=1 and discard the aux write (pipe result is younger).
REQ-021 In NORMAL, aux_valid with pipe request and differing wsel SHALL give aux_ready=0 (aux blocked).
REQ-022 aux_valid with aux_wsel==0 SHALL give aux_ready=1 in any state, no write, no pipe_stall.
REQ-023 aux_ready, pipe_stall, prio_active SHALL be combinational from current state and inputs.
REQ-024 wait_cnt (4 bits) SHALL increment at posedge when aux blocked, clear when aux_valid=0 or aux_ready=1.
REQ-025 NORMAL->PRIORITY SHALL occur at the posedge where aux is blocked and wait_cnt==STARVE_LIMIT-1.
REQ-026 In PRIORITY with aux_valid=1 and aux_wsel!=0: aux granted, aux_ready=1, pipe_stall=1, no pipe write.
REQ-027 In PRIORITY with aux_valid=0: behave as NORMAL grant, pipe_stall=0.
REQ-028 PRIORITY SHALL last exactly one cycle, then NORMAL with wait_cnt=0.
REQ-029 Aux sender SHALL hold aux_valid/aux_wsel/aux_wdat stable until aux_ready; transfer occurs at posedge with aux_valid&aux_ready.
REQ-030 Output stage registered: at posedge after a grant, rf_WEN=1, rf_wsel/rf_wdat = winner's values; latency 1 cycle; register file commits on following negedge.
REQ-031 Cycles with no granted write SHALL register rf_WEN=0, rf_wsel=0, rf_wdat=0.
REQ-032 At most one write per cycle; rf_WEN SHALL never be 1 with rf_wsel=0.

Reset
REQ-033 nRST low SHALL immediately force state NORMAL, wait_cnt=0, rf_WEN=0, rf_wsel=0, rf_wdat=0, prio_active=0.
REQ-034 During reset, aux_ready=0 and pipe_stall=0 regardless of inputs.
REQ-035 Reset mid-operation SHALL drop any blocked aux request without acknowledgement and cancel any registered write.

Verification
REQ-036 pipe_wen=1,wsel=5,wdat=0xAAAA5555, aux idle -> next cycle rf_WEN=1,rf_wsel=5,rf_wdat=0xAAAA5555.
REQ-037 pipe idle, aux_valid=1,wsel=7,wdat=0x12 -> aux_ready=1 same cycle; next cycle rf_WEN=1,rf_wsel=7,rf_wdat=0x12.
REQ-038 pipe writes r3 every cycle, aux_valid to r9 held, STARVE_LIMIT=4 -> aux_ready=0 for 4 cycles; 5th cycle prio_active=1, pipe_stall=1, aux_ready=1; next cycle rf_wsel=9; following cycle pipe r3 resumes.
REQ-039 pipe r4=0x1 and aux r4=0x2 same cycle -> aux_ready=1, next cycle rf_wsel=4,rf_wdat=0x1, no second write.
REQ-040 pipe_wen=1 with wsel=0, aux_valid wsel=0 -> aux_ready=1, rf_WEN stays 0.
REQ-041 nRST pulsed low while aux blocked (wait_cnt=2) -> outputs zero immediately; after release aux granted in NORMAL with wait_cnt restarting at 0.
